wiscsc15_fetch: RTL and testbench

Instruction fetch stage of the WISC-SC15 core. It sits directly upstream of the control unit, which decodes opcode[3:0].
- Holds the PC and issues requests to instruction memory over a req/rdy handshake.
- Latches the returned word into a one-entry instruction register and presents it, with its PC and PC+1, to decode and control.
- Accepts PC redirects from branch/call/ret resolution and stops permanently on HALT.

---
 rtl/wiscsc15_fetch_pkg.sv | 37 +++
 rtl/wiscsc15_fetch_if.sv | 34 +++
 rtl/wiscsc15_fetch.sv | 96 +++++++++
 tb/tb_wiscsc15_fetch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wiscsc15_fetch_pkg.sv
// Shared WISC-SC15 definitions: opcode map, fetch-state encoding, default widths.
// The opcode constants are also imported by the control unit.
package wiscsc15_pkg;

  localparam int PC_W_DEF    = 16;
  localparam int INSTR_W_DEF = 16;
  localparam int OPCODE_W    = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD    = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_PADDSB = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_SUB    = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_AND    = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_NOR    = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_SLL    = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_SRL    = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_SRA    = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_LW     = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_SW     = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_LHB    = 4'hA;
  localparam logic [OPCODE_W-1:0] OP_LLB    = 4'hB;
  localparam logic [OPCODE_W-1:0] OP_B      = 4'hC;
  localparam logic [OPCODE_W-1:0] OP_CALL   = 4'hD;
  localparam logic [OPCODE_W-1:0] OP_RET    = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HALT   = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    REDIR = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  function automatic logic is_halt(input logic [OPCODE_W-1:0] op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/wiscsc15_fetch_if.sv
// Fetch-stage bundle: instruction-memory req/rdy handshake, decode-side control and outputs.
// master = fetch stage, slave = memory plus decode/control environment.
interface wiscsc15_fetch_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rdy;
  logic [INSTR_W-1:0] imem_data;

  logic               stall;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;

  logic [INSTR_W-1:0] instr;
  logic [3:0]         opcode;
  logic [PC_W-1:0]    instr_pc;
  logic [PC_W-1:0]    pc_inc;
  logic               instr_valid;
  logic               halted;

  modport master (
    output imem_req, imem_addr, instr, opcode, instr_pc, pc_inc, instr_valid, halted,
    input  imem_rdy, imem_data, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_pc, pc_inc, instr_valid, halted,
    output imem_rdy, imem_data, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/wiscsc15_fetch.sv
// WISC-SC15 fetch stage: PC, fetch FSM and one-entry instruction register.
// One fetch cycle plus one hold cycle per instruction; stall holds the IR, redirect flushes it.
module wiscsc15_fetch
  import wiscsc15_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  wiscsc15_fetch_if.master       bus
);

  fetch_state_e       state_q;
  logic               req_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    instr_pc_q;
  logic [PC_W-1:0]    pc_inc_q;
  logic               valid_q;
  logic               halted_q;

  logic [PC_W-1:0]    pc_inc_d;
  logic [3:0]         fetched_op_d;

  assign pc_inc_d     = pc_q + PC_W'(1);
  assign fetched_op_d = bus.imem_data[INSTR_W-1 -: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REDIR;
      req_q      <= 1'b0;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      pc_inc_q   <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else if (state_q == HALT) begin
      // Terminal: only the consumed HALT word is retired; redirect and rdy are ignored.
      if (!bus.stall) begin
        valid_q <= 1'b0;
      end
    end else if (bus.redirect) begin
      state_q <= REDIR;
      req_q   <= 1'b0;
      pc_q    <= bus.redirect_pc;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        REDIR: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (bus.imem_rdy) begin
            instr_q    <= bus.imem_data;
            instr_pc_q <= pc_q;
            pc_inc_q   <= pc_inc_d;
            pc_q       <= pc_inc_d;
            valid_q    <= 1'b1;
            req_q      <= 1'b0;
            if (is_halt(fetched_op_d)) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              state_q  <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            valid_q <= 1'b0;
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= REDIR;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[INSTR_W-1 -: 4];
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc_inc      = pc_inc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_wiscsc15_fetch.sv
// Directed scenarios followed by a randomized run checked against rule-level expectations.
module tb_wiscsc15_fetch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  wiscsc15_fetch_if #(.PC_W(16), .INSTR_W(16)) bus ();

  wiscsc15_fetch #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] m;
    m = a % 16'd15;
    return {m[3:0], a[11:0] ^ 12'hA5C};
  endfunction

  // Fetch at addr k after (lat-1) wait cycles; leaves the stage back in FETCH at k+1.
  task automatic fetch_lat(input int lat, input logic [15:0] k, input logic [15:0] data);
    for (int c = 0; c < lat - 1; c++) begin
      chk("wait_req", 32'(bus.imem_req), 32'd1);
      chk("wait_addr", 32'(bus.imem_addr), 32'(k));
      step();
    end
    chk("lat_req", 32'(bus.imem_req), 32'd1);
    chk("lat_addr", 32'(bus.imem_addr), 32'(k));
    bus.imem_rdy = 1'b1;
    bus.imem_data = data;
    step();
    bus.imem_rdy = 1'b0;
    chk("lat_instr", 32'(bus.instr), 32'(data));
    chk("lat_ipc", 32'(bus.instr_pc), 32'(k));
    chk("lat_valid", 32'(bus.instr_valid), 32'd1);
    chk("lat_req_lo", 32'(bus.imem_req), 32'd0);
    step();
    chk("lat_consumed", 32'(bus.instr_valid), 32'd0);
    chk("lat_next_addr", 32'(bus.imem_addr), 32'(k + 16'd1));
  endtask

  logic [15:0] exp_pc, p_addr, p_rpc, p_instr;
  logic        p_req, p_rdy, p_redir, p_stall, p_valid;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.imem_rdy = 1'b0;
    bus.imem_data = '0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;

    // Reset state
    step();
    step();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'h0);
    chk("rst_instr", 32'(bus.instr), 32'h0);
    chk("rst_ipc", 32'(bus.instr_pc), 32'h0);
    chk("rst_pcinc", 32'(bus.pc_inc), 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_opcode", 32'(bus.opcode), 32'h0);

    // First fetch with immediate rdy
    rst = 1'b0;
    step();
    chk("c1_req", 32'(bus.imem_req), 32'd1);
    chk("c1_addr", 32'(bus.imem_addr), 32'h0);
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'h1234;
    step();
    bus.imem_rdy = 1'b0;
    chk("f1_instr", 32'(bus.instr), 32'h1234);
    chk("f1_ipc", 32'(bus.instr_pc), 32'h0);
    chk("f1_pcinc", 32'(bus.pc_inc), 32'h1);
    chk("f1_valid", 32'(bus.instr_valid), 32'd1);
    chk("f1_opcode", 32'(bus.opcode), 32'h1);
    chk("f1_addr", 32'(bus.imem_addr), 32'h1);
    chk("f1_req", 32'(bus.imem_req), 32'd0);
    step();
    chk("f1_consumed", 32'(bus.instr_valid), 32'd0);
    chk("f1_refetch", 32'(bus.imem_req), 32'd1);

    // Memory latency 3
    fetch_lat(3, 16'h0001, 16'h2001);
    fetch_lat(3, 16'h0002, 16'h2002);

    // Stall holds the instruction register
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'h3333;
    step();
    bus.imem_rdy = 1'b0;
    bus.stall = 1'b1;
    chk("st_valid0", 32'(bus.instr_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("st_valid", 32'(bus.instr_valid), 32'd1);
      chk("st_instr", 32'(bus.instr), 32'h3333);
      chk("st_ipc", 32'(bus.instr_pc), 32'h3);
      chk("st_req", 32'(bus.imem_req), 32'd0);
    end
    bus.stall = 1'b0;
    step();
    chk("st_release_valid", 32'(bus.instr_valid), 32'd0);
    chk("st_release_req", 32'(bus.imem_req), 32'd1);
    chk("st_release_addr", 32'(bus.imem_addr), 32'h4);

    // Redirect collides with rdy
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'h5555;
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0040;
    step();
    bus.imem_rdy = 1'b0;
    bus.redirect = 1'b0;
    chk("rd_valid", 32'(bus.instr_valid), 32'd0);
    chk("rd_req", 32'(bus.imem_req), 32'd0);
    chk("rd_addr", 32'(bus.imem_addr), 32'h40);
    chk("rd_instr_kept", 32'(bus.instr), 32'h3333);
    step();
    chk("rd_req_back", 32'(bus.imem_req), 32'd1);
    chk("rd_addr_back", 32'(bus.imem_addr), 32'h40);

    // PC wrap at 16'hFFFF
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    step();
    bus.redirect = 1'b0;
    chk("wr_addr", 32'(bus.imem_addr), 32'hFFFF);
    step();
    chk("wr_req", 32'(bus.imem_req), 32'd1);
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'h0000;
    step();
    bus.imem_rdy = 1'b0;
    chk("wr_ipc", 32'(bus.instr_pc), 32'hFFFF);
    chk("wr_pcinc", 32'(bus.pc_inc), 32'h0);
    chk("wr_addr_next", 32'(bus.imem_addr), 32'h0);
    step();

    // HALT at pc 5
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0005;
    step();
    bus.redirect = 1'b0;
    step();
    chk("h_req", 32'(bus.imem_req), 32'd1);
    bus.stall = 1'b1;
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'hF000;
    step();
    bus.imem_rdy = 1'b0;
    chk("h_halted", 32'(bus.halted), 32'd1);
    chk("h_valid", 32'(bus.instr_valid), 32'd1);
    chk("h_req_lo", 32'(bus.imem_req), 32'd0);
    chk("h_addr", 32'(bus.imem_addr), 32'h6);
    chk("h_opcode", 32'(bus.opcode), 32'hF);
    chk("h_ipc", 32'(bus.instr_pc), 32'h5);
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0080;
    bus.imem_rdy = 1'b1;
    bus.imem_data = 16'h1111;
    step();
    bus.redirect = 1'b0;
    bus.imem_rdy = 1'b0;
    chk("h_redir_ign_addr", 32'(bus.imem_addr), 32'h6);
    chk("h_redir_ign_valid", 32'(bus.instr_valid), 32'd1);
    chk("h_redir_ign_instr", 32'(bus.instr), 32'hF000);
    chk("h_redir_ign_req", 32'(bus.imem_req), 32'd0);
    bus.stall = 1'b0;
    step();
    chk("h_consumed", 32'(bus.instr_valid), 32'd0);
    chk("h_sticky", 32'(bus.halted), 32'd1);
    step();
    step();
    chk("h_stay_req", 32'(bus.imem_req), 32'd0);
    chk("h_stay_addr", 32'(bus.imem_addr), 32'h6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("h_rst_halted", 32'(bus.halted), 32'd0);
    chk("h_rst_addr", 32'(bus.imem_addr), 32'h0);
    chk("h_rst_req", 32'(bus.imem_req), 32'd0);

    // Randomized traffic: data never carries HALT on a real response
    exp_pc  = 16'h0000;
    p_req   = bus.imem_req;
    p_valid = bus.instr_valid;
    p_addr  = bus.imem_addr;
    p_instr = bus.instr;
    p_rdy   = 1'b0;
    p_redir = 1'b0;
    p_stall = 1'b0;
    p_rpc   = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc > 0) begin
        if (p_redir) begin
          exp_pc = p_rpc;
          chk("r_redir_valid", 32'(bus.instr_valid), 32'd0);
          chk("r_redir_req", 32'(bus.imem_req), 32'd0);
          chk("r_redir_addr", 32'(bus.imem_addr), 32'(exp_pc));
        end else if (p_req && p_rdy) begin
          exp_pc = p_addr + 16'd1;
          chk("r_acc_valid", 32'(bus.instr_valid), 32'd1);
          chk("r_acc_instr", 32'(bus.instr), 32'(mem_word(p_addr)));
          chk("r_acc_ipc", 32'(bus.instr_pc), 32'(p_addr));
          chk("r_acc_pcinc", 32'(bus.pc_inc), 32'(exp_pc));
          chk("r_acc_req", 32'(bus.imem_req), 32'd0);
          chk("r_acc_addr", 32'(bus.imem_addr), 32'(exp_pc));
        end else if (p_valid) begin
          if (p_stall) begin
            chk("r_hold_valid", 32'(bus.instr_valid), 32'd1);
            chk("r_hold_instr", 32'(bus.instr), 32'(p_instr));
            chk("r_hold_req", 32'(bus.imem_req), 32'd0);
          end else begin
            chk("r_cons_valid", 32'(bus.instr_valid), 32'd0);
            chk("r_cons_req", 32'(bus.imem_req), 32'd1);
            chk("r_cons_addr", 32'(bus.imem_addr), 32'(exp_pc));
          end
        end else begin
          chk("r_req", 32'(bus.imem_req), 32'd1);
          chk("r_addr", 32'(bus.imem_addr), 32'(exp_pc));
        end
        chk("r_halted", 32'(bus.halted), 32'd0);
      end

      p_req   = bus.imem_req;
      p_valid = bus.instr_valid;
      p_addr  = bus.imem_addr;
      p_instr = bus.instr;
      p_rdy   = p_req ? ($urandom % 3 == 0) : ($urandom % 4 == 0);
      p_redir = ($urandom % 12 == 0);
      p_rpc   = 16'($urandom);
      p_stall = ($urandom % 2 == 1);
      bus.imem_rdy    = p_rdy;
      bus.imem_data   = (p_req && p_rdy) ? mem_word(p_addr) : (16'hF000 | 16'($urandom % 4096));
      bus.redirect    = p_redir;
      bus.redirect_pc = p_rpc;
      bus.stall       = p_stall;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
